// File: rtl/dht11_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dht11_ctrl
// Description : DHT11 single-wire humidity/temperature sensor controller.
//               Issues the host start pulse, decodes the 40-bit reply and
//               validates its checksum.
// Revision    : 1.0 - initial release
// ============================================================================
module dht11_ctrl #(
    parameter int TICKS_PER_US  = 100,
    parameter int START_LOW_US  = 18000,
    parameter int TIMEOUT_US    = 200,
    parameter int BIT_THRESH_US = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        data,
    output logic        data_oe,
    output logic        busy,
    output logic [15:0] hum,
    output logic [15:0] temp,
    output logic        valid,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START_LOW = 3'd1;
    localparam logic [2:0] S_WAIT_RESP = 3'd2;
    localparam logic [2:0] S_RESP_LOW  = 3'd3;
    localparam logic [2:0] S_RESP_HIGH = 3'd4;
    localparam logic [2:0] S_BIT_LOW   = 3'd5;
    localparam logic [2:0] S_BIT_HIGH  = 3'd6;
    localparam logic [2:0] S_CHECK     = 3'd7;

    localparam int             c_PW          = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
    localparam logic [c_PW-1:0] c_PRESC_MAX  = c_PW'(TICKS_PER_US - 1);
    localparam logic [14:0]    c_START_LAST  = 15'(START_LOW_US - 1);
    localparam logic [14:0]    c_TIMEOUT_LAST = 15'(TIMEOUT_US - 1);
    localparam logic [14:0]    c_THRESH      = 15'(BIT_THRESH_US);

    logic [2:0]      r_state;
    logic [2:0]      w_next;
    logic            r_sync1;
    logic            r_sync2;
    logic            r_prev;
    logic            w_rise;
    logic            w_fall;
    logic [c_PW-1:0] r_presc;
    logic            w_tick;
    logic [14:0]     r_us;
    logic            w_state_chg;
    logic            w_timeout;
    logic            w_wait_state;
    logic            w_bit;
    logic [39:0]     r_shift;
    logic [5:0]      r_bit_cnt;
    logic [7:0]      w_sum;
    logic [15:0]     r_hum;
    logic [15:0]     r_temp;
    logic            r_valid;
    logic            r_err;
    logic [1:0]      r_err_code;

    assign w_rise      = r_sync2 & ~r_prev;
    assign w_fall      = ~r_sync2 & r_prev;
    assign w_tick      = (r_presc == c_PRESC_MAX);
    assign w_state_chg = (w_next != r_state);
    assign w_sum       = r_shift[39:32] + r_shift[31:24] + r_shift[23:16] + r_shift[15:8];
    assign w_wait_state = (r_state == S_WAIT_RESP) || (r_state == S_RESP_LOW) ||
                          (r_state == S_RESP_HIGH) || (r_state == S_BIT_LOW)  ||
                          (r_state == S_BIT_HIGH);

    // The falling edge is seen one cycle before the us counter would reach
    // the full high time, so a count of BIT_THRESH_US means "more than".
    assign w_bit = (r_us >= c_THRESH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE:      if (start) w_next = S_START_LOW;
            S_START_LOW: if (w_tick && (r_us == c_START_LAST)) w_next = S_WAIT_RESP;
            S_WAIT_RESP: if (w_fall) w_next = S_RESP_LOW;
            S_RESP_LOW:  if (w_rise) w_next = S_RESP_HIGH;
            S_RESP_HIGH: if (w_fall) w_next = S_BIT_LOW;
            S_BIT_LOW:   if (w_rise) w_next = S_BIT_HIGH;
            S_BIT_HIGH:  if (w_fall) w_next = (r_bit_cnt == 6'd39) ? S_CHECK : S_BIT_LOW;
            S_CHECK:     w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
        // An expected edge arriving on the expiry cycle still counts as progress.
        if (w_wait_state && w_tick && (r_us == c_TIMEOUT_LAST) && (w_next == r_state)) begin
            w_timeout = 1'b1;
            w_next    = S_IDLE;
        end
    end

    always_comb begin
        data_oe = (r_state == S_START_LOW);
        busy    = (r_state != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_prev     <= 1'b0;
            r_presc    <= '0;
            r_us       <= '0;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_hum      <= '0;
            r_temp     <= '0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
        end else begin
            r_sync1 <= data;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;

            if (w_state_chg) begin
                r_presc <= '0;
                r_us    <= '0;
            end else if (w_tick) begin
                r_presc <= '0;
                r_us    <= r_us + 15'd1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end

            r_valid <= 1'b0;
            r_err   <= 1'b0;

            if ((r_state == S_IDLE) && start) begin
                r_shift   <= '0;
                r_bit_cnt <= '0;
            end

            if ((r_state == S_BIT_HIGH) && w_fall) begin
                r_shift   <= {r_shift[38:0], w_bit};
                r_bit_cnt <= r_bit_cnt + 6'd1;
            end

            if (w_timeout) begin
                r_err      <= 1'b1;
                r_err_code <= 2'b01;
            end

            if (r_state == S_CHECK) begin
                if (w_sum == r_shift[7:0]) begin
                    r_hum   <= r_shift[39:24];
                    r_temp  <= r_shift[23:8];
                    r_valid <= 1'b1;
                end else begin
                    r_err      <= 1'b1;
                    r_err_code <= 2'b10;
                end
            end
        end
    end

    assign hum      = r_hum;
    assign temp     = r_temp;
    assign valid    = r_valid;
    assign err      = r_err;
    assign err_code = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_dht11_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dht11_ctrl
// Description : Directed bench for dht11_ctrl with a behavioural sensor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dht11_ctrl;

    localparam int TPU = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sens;
    wire         line;
    logic        data_oe;
    logic        busy;
    logic [15:0] hum;
    logic [15:0] temp;
    logic        valid;
    logic        err;
    logic [1:0]  err_code;

    int total = 0;
    int bad   = 0;
    int valid_cnt = 0;
    int err_cnt   = 0;
    int both_cnt  = 0;
    int v0;
    int e0;
    int cyc;

    // Open-drain line with pull-up: low when either side pulls it down.
    assign line = data_oe ? 1'b0 : sens;

    always #5 clk = ~clk;

    dht11_ctrl #(
        .TICKS_PER_US (TPU),
        .START_LOW_US (20),
        .TIMEOUT_US   (200),
        .BIT_THRESH_US(50)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .data    (line),
        .data_oe (data_oe),
        .busy    (busy),
        .hum     (hum),
        .temp    (temp),
        .valid   (valid),
        .err     (err),
        .err_code(err_code)
    );

    always @(posedge clk) begin
        if (valid) valid_cnt++;
        if (err) err_cnt++;
        if (valid && err) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic hold_us(input int n);
        repeat (n * TPU) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_oe(input logic lvl, input string tag);
        int n = 0;
        while ((data_oe !== lvl) && (n < 5000)) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, data_oe}, {31'd0, lvl});
    endtask

    // Sensor model: response, 40 bits MSB first, trailing low, release.
    task automatic send_frame(input logic [39:0] f, input int h0, input int h1, input int sb);
        int h;
        wait_oe(1'b1, "oe_high");
        wait_oe(1'b0, "oe_release");
        hold_us(20);
        sens = 1'b0;
        hold_us(80);
        sens = 1'b1;
        hold_us(80);
        for (int i = 0; i < 40; i++) begin
            sens = 1'b0;
            hold_us(20);
            sens = 1'b1;
            h = f[39-i] ? h1 : h0;
            if (i == sb) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                check("busy_mid_frame", {31'd0, busy}, 32'd1);
                repeat (h * TPU - 1) @(negedge clk);
            end else begin
                hold_us(h);
            end
        end
        sens = 1'b0;
        hold_us(20);
        sens = 1'b1;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        sens  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data_oe", {31'd0, data_oe}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_hum", {16'd0, hum}, 32'h0000);
        check("rst_temp", {16'd0, temp}, 32'h0000);
        check("rst_err_code", {30'd0, err_code}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Good frame, 27/70 us bit high times
        v0 = valid_cnt; e0 = err_cnt;
        pulse_start();
        send_frame(40'h37_00_18_00_4F, 27, 70, -1);
        repeat (10) @(negedge clk);
        check("a_valid_pulses", valid_cnt - v0, 32'd1);
        check("a_err_pulses", err_cnt - e0, 32'd0);
        check("a_hum", {16'd0, hum}, 32'h3700);
        check("a_temp", {16'd0, temp}, 32'h1800);
        check("a_busy", {31'd0, busy}, 32'd0);

        // Checksum mismatch keeps the previous reading
        v0 = valid_cnt; e0 = err_cnt;
        pulse_start();
        send_frame(40'h37_00_18_00_50, 27, 70, -1);
        repeat (10) @(negedge clk);
        check("cs_err_pulses", err_cnt - e0, 32'd1);
        check("cs_valid_pulses", valid_cnt - v0, 32'd0);
        check("cs_err_code", {30'd0, err_code}, 32'd2);
        check("cs_hum", {16'd0, hum}, 32'h3700);
        check("cs_temp", {16'd0, temp}, 32'h1800);

        // No sensor response: err 200 us (400 clocks) after release
        e0 = err_cnt;
        pulse_start();
        wait_oe(1'b1, "to_oe_high");
        wait_oe(1'b0, "to_oe_release");
        cyc = 0;
        while ((err !== 1'b1) && (cyc < 1000)) begin
            @(negedge clk);
            cyc++;
        end
        check("to_latency", cyc, 32'd400);
        check("to_err_code", {30'd0, err_code}, 32'd1);
        check("to_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("to_err_one_cycle", {31'd0, err}, 32'd0);
        check("to_err_pulses", err_cnt - e0, 32'd1);
        check("to_hum", {16'd0, hum}, 32'h3700);

        // Threshold 50/51 us, start pulsed during bit 10
        v0 = valid_cnt; e0 = err_cnt;
        pulse_start();
        send_frame(40'h12_34_56_78_14, 50, 51, 9);
        repeat (10) @(negedge clk);
        check("b_valid_pulses", valid_cnt - v0, 32'd1);
        check("b_err_pulses", err_cnt - e0, 32'd0);
        check("b_hum", {16'd0, hum}, 32'h1234);
        check("b_temp", {16'd0, temp}, 32'h5678);
        check("b_busy", {31'd0, busy}, 32'd0);

        // Reset in the middle of START_LOW
        pulse_start();
        repeat (10) @(negedge clk);
        check("r_oe_before", {31'd0, data_oe}, 32'd1);
        rst = 1'b1;
        #1;
        check("r_oe_async", {31'd0, data_oe}, 32'd0);
        check("r_busy_async", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("r_hum_cleared", {16'd0, hum}, 32'h0000);
        check("r_err_code_cleared", {30'd0, err_code}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        v0 = valid_cnt; e0 = err_cnt;
        pulse_start();
        send_frame(40'h37_00_18_00_4F, 27, 70, -1);
        repeat (10) @(negedge clk);
        check("r_valid_pulses", valid_cnt - v0, 32'd1);
        check("r_err_pulses", err_cnt - e0, 32'd0);
        check("r_hum", {16'd0, hum}, 32'h3700);
        check("r_temp", {16'd0, temp}, 32'h1800);

        check("valid_err_overlap", both_cnt, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dht11_ctrl.md
DHT11_CTRL -- requirements
Module: dht11_ctrl

Interface
REQ-001 The block SHALL have parameter TICKS_PER_US, default 100, giving clk cycles per microsecond (100 MHz clk).
REQ-002 The block SHALL have parameter START_LOW_US, default 18000, giving the host start-pulse low time in us.
REQ-003 The block SHALL have parameter TIMEOUT_US, default 200, giving the maximum wait for any expected line edge.
REQ-004 The block SHALL have parameter BIT_THRESH_US, default 50, giving the high-time above which a bit decodes as 1.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port start, input, 1 bit: request one sensor reading; sampled only in IDLE.
REQ-008 The block SHALL have port data, input, 1 bit: raw single-wire line level (asynchronous).
REQ-009 The block SHALL have port data_oe, output, 1 bit: 1 = drive line low (open-drain), 0 = release.
REQ-010 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 The block SHALL have port hum, output, 16 bits: humidity {integral, decimal}, last good reading.
REQ-012 The block SHALL have port temp, output, 16 bits: temperature {integral, decimal}, last good reading.
REQ-013 The block SHALL have port valid, output, 1 bit: one-cycle pulse when hum/temp update.
REQ-014 The block SHALL have port err, output, 1 bit: one-cycle pulse on a failed reading.
REQ-015 The block SHALL have port err_code, output, 2 bits: 01 timeout, 10 checksum, held until the next err.

Function
REQ-016 data SHALL pass through a 2-FF synchronizer; all edge detection SHALL use the synchronized value (2-cycle latency).
REQ-017 A prescaler SHALL produce a 1-us tick every TICKS_PER_US cycles; a 15-bit us counter SHALL clear on every state change.
REQ-018 The FSM SHALL have states IDLE, START_LOW, WAIT_RESP, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK.
REQ-019 IDLE -> START_LOW on start=1; start in any other state SHALL be ignored.
REQ-020 START_LOW SHALL hold data_oe=1 for START_LOW_US, then go to WAIT_RESP with data_oe=0.
REQ-021 WAIT_RESP -> RESP_LOW on falling edge; RESP_LOW -> RESP_HIGH on rising edge; RESP_HIGH -> BIT_LOW on falling edge.
REQ-022 BIT_LOW -> BIT_HIGH on rising edge; BIT_HIGH -> BIT_LOW on falling edge, shifting in bit = (high time > BIT_THRESH_US).
REQ-023 Bits SHALL shift MSB first into a 40-bit register: byte order hum_int, hum_dec, temp_int, temp_dec, checksum.
REQ-024 After the falling edge ending bit 40, the FSM SHALL enter CHECK; bit count SHALL be a 6-bit counter reaching 40.
REQ-025 CHECK SHALL compare checksum with the low 8 bits of the sum of the four data bytes (carry discarded).
REQ-026 On match, the block SHALL load hum/temp and pulse valid in the cycle after CHECK, then return to IDLE.
REQ-027 On mismatch, the block SHALL pulse err with err_code=10, leave hum/temp unchanged, and return to IDLE.
REQ-028 In WAIT_RESP..BIT_HIGH, the us counter reaching TIMEOUT_US SHALL pulse err with err_code=01 and return to IDLE.
REQ-029 The block SHALL never pulse valid and err in the same cycle; data_oe SHALL be 1 only in START_LOW.

Reset
REQ-030 While rst=1, state SHALL be IDLE and data_oe, busy, valid, err SHALL be 0; hum, temp SHALL be 0x0000; err_code SHALL be 00; counters and shift register SHALL be 0.
REQ-031 rst asserted mid-reading SHALL release the line immediately (asynchronously) and discard partial data.

Verification
REQ-032 The bench SHALL cover: model sends 0x37,0x00,0x18,0x00,0x4F -> one valid pulse, hum=0x3700, temp=0x1800, busy falls.
REQ-033 The bench SHALL cover: same frame with checksum 0x50 -> err pulse, err_code=10, hum/temp keep the prior values.
REQ-034 The bench SHALL cover: no sensor response after release -> err with err_code=01 exactly TIMEOUT_US us after START_LOW ends.
REQ-035 The bench SHALL cover: bit high times of 27 us and 70 us -> decode as 0 and 1; 50 us -> 0, 51 us -> 1.
REQ-036 The bench SHALL cover: start pulsed during bit 10 -> ignored, frame completes normally with one valid pulse.
REQ-037 The bench SHALL cover: rst asserted during START_LOW -> data_oe=0 in the same cycle, busy=0, then a new start runs a full reading.
